instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer that accepts one 32-bit instruction per valid/ready handshake and drives the register file, ALU and data memory of the datapath through decode, execute, memory and write-back phases. It executes LW, SW, ADD and SUB, signals completion with `done` and rejects undefined opcodes with `illegal`. It sits between the instruction source and the datapath, and replaces ad-hoc opcode-to-control decoding with an explicit sequenced FSM.

## Interface

**Parameters**

- `WORDSIZE`, default 64: datapath word width.
- `SIZE`, default 32: instruction width.

**Ports**

- `clk` input 1: clock, rising-edge.
- `rst` input 1: asynchronous reset, active-high.
- `instr_valid` input 1: instruction offered.
- `instr_ready` output 1: sequencer can accept an instruction.
- `instruction` input SIZE: instruction word.
- `done` output 1: instruction completes this cycle.
- `illegal` output 1: undefined opcode rejected this cycle.
- `rf_write_enable` output 1: register file write strobe.
- `rf_write_addr` output 5: register file write address.
- `rf_write_data` output WORDSIZE: register file write data.
- `rf_addr_a` output 5: register file read port A address.
- `rf_addr_b` output 5: register file read port B address.
- `rf_data_a` input WORDSIZE: port A data, combinational read.
- `rf_data_b` input WORDSIZE: port B data, combinational read.
- `alu_op` output 1: 0 = add, 1 = sub. The ALU operands are `rf_data_a` and `rf_data_b`.
- `alu_result` input WORDSIZE: ALU result, combinational.
- `dm_write_enable` output 1: data memory write strobe.
- `dm_addr` output 5: data memory address.
- `dm_data_input` output WORDSIZE: data memory write data.
- `dm_read` output 1: data memory read strobe. The read is synchronous; data is valid the cycle after the strobe.
- `dm_data_output` input WORDSIZE: data memory read data.

One clock; reset is asynchronous and active-high.

## Operation

**Instruction fields**

- `[2:0]` opcode: 0 = LW, 1 = SW, 2 = ADD, 3 = SUB. Opcodes 4–7 are illegal.
- `[11:7]` rd.
- `[19:15]` rs1.
- `[24:20]` rs2.
- `[29:25]` imm5, unsigned.

**Accept and decode**

- An instruction is accepted on a rising edge where `instr_valid && instr_ready`. It is latched into an internal instruction register (`ir`).
- `rf_addr_a` = `ir.rs1` and `rf_addr_b` = `ir.rs2` in every non-IDLE state.

**FSM states:** IDLE, DECODE, EXEC, MEM, WB.

- **IDLE:** `instr_ready`=1. Go to DECODE on accept.
- **DECODE:** If the opcode is illegal, `illegal`=1 for this cycle, go to IDLE, no writes occur. Otherwise go to EXEC.
- **EXEC:**
  - ADD/SUB: `alu_op` = opcode[0]; latch `alu_result` into the result register; go to WB.
  - LW: `dm_addr` = `rf_data_a[4:0] + imm5` (5-bit, wraps mod 32); `dm_read`=1; go to MEM.
  - SW: `dm_addr` as for LW; `dm_data_input` = `rf_data_b`; `dm_write_enable`=1; `done`=1; go to IDLE.
- **MEM:** latch `dm_data_output` into the result register; go to WB.
- **WB:** `rf_write_enable`=1, `rf_write_addr`=rd, `rf_write_data`=result; `done`=1; go to IDLE.

**Output behaviour**

- All outputs are Moore functions of the state and `ir`. Strobes are low in every state not listed above.
- ADD/SUB arithmetic is WORDSIZE-bit modulo 2^WORDSIZE; underflow wraps and no flags are produced.

## Timing

- Reset (async, asserted at any time, including mid-instruction): state=IDLE, `ir`=0, result=0.
  - Every output is 0 while `rst`=1, including `instr_ready`.
  - An in-flight instruction is abandoned; no partial write is issued after reset.
- `instr_ready` rises in the first cycle after `rst` deasserts.
- Counting the accept edge as t0, `done` is high during cycle:
  - t3 for ADD/SUB,
  - t4 for LW,
  - t2 for SW.
- `illegal` is high during cycle t1.
- The next instruction can be accepted at the first rising edge after the `done` or `illegal` cycle.
- `instr_valid` while busy is ignored; the instruction is not consumed.
- An instruction whose rd equals its rs1 or rs2 reads the old value; the write lands only in WB.

## Configuration

- `INSTR_SEQ_ZERO_REG_EN` defined: a write-back to rd=0 keeps `rf_write_enable`=0. `done` still pulses in WB.
- Undefined: rd=0 is written like any other register.

## Test plan

Initial state: register file r1=10, r2=3; memory cleared.

- ADD `0x00208182` -> `done` at t3; r3 = 13; `alu_op`=0 during EXEC.
- SUB `0x00208183` -> r3 = 7. Then SUB with rs1=2, rs2=1 -> rd = 2^64−7 (wrap).
- SW `0x08208001` -> `dm_write_enable` at t2; `dm_addr`=14; `dm_data_input`=3. Then LW `0x08008200` -> `dm_read` at t2, `done` at t4, r4 = 3.
- Address wrap: r1=30, SW with imm5=4 -> `dm_addr`=2.
- Illegal opcode `0x00000005` -> `illegal`=1 at t1 only; no `rf_write_enable`, no `dm_write_enable`; `instr_ready`=1 at t2.
- Assert `rst` during MEM of an LW -> all outputs 0 immediately; no write to r4. After release, ADD completes normally. With `INSTR_SEQ_ZERO_REG_EN` defined, ADD rd=0 -> `done`=1 with `rf_write_enable`=0.

Source files
------------

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle instruction sequencer. Accepts one instruction per
//               valid/ready handshake and steps it through DECODE, EXEC, MEM
//               and WB, driving the register file, ALU and data memory of the
//               datapath. Executes LW, SW, ADD and SUB; flags opcodes 4-7 as
//               illegal.
//
// Parameters  : WORDSIZE - datapath word width (default 64)
//               SIZE     - instruction width (default 32, must be >= 30)
//
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               instr_valid/ready   - instruction handshake
//               instruction         - instruction word
//               done, illegal       - completion / rejection pulses
//               rf_*                - register file write port + two read
//                                     address ports, combinational read data
//               alu_op, alu_result  - ALU control (0 add, 1 sub) and result
//               dm_*                - data memory address, write data/strobe,
//                                     synchronous read strobe and read data
//
// Build option: define INSTR_SEQ_ZERO_REG_EN to suppress register-file
//               writes to r0 (done still pulses in WB).
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [SIZE-1:0]     instruction,

    output logic                done,
    output logic                illegal,

    output logic                rf_write_enable,
    output logic [4:0]          rf_write_addr,
    output logic [WORDSIZE-1:0] rf_write_data,
    output logic [4:0]          rf_addr_a,
    output logic [4:0]          rf_addr_b,
    input  logic [WORDSIZE-1:0] rf_data_a,
    input  logic [WORDSIZE-1:0] rf_data_b,

    output logic                alu_op,
    input  logic [WORDSIZE-1:0] alu_result,

    output logic                dm_write_enable,
    output logic [4:0]          dm_addr,
    output logic [WORDSIZE-1:0] dm_data_input,
    output logic                dm_read,
    input  logic [WORDSIZE-1:0] dm_data_output
);

    // ------------------------------------------------------------------------
    // Opcode encodings
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_OP_LW  = 3'd0;
    localparam logic [2:0] c_OP_SW  = 3'd1;
    localparam logic [2:0] c_OP_ADD = 3'd2;
    localparam logic [2:0] c_OP_SUB = 3'd3;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [SIZE-1:0]       r_ir;
    logic [WORDSIZE-1:0]   r_result;

    // ------------------------------------------------------------------------
    // Instruction register field decode
    // ------------------------------------------------------------------------
    logic [2:0]            w_opcode;
    logic [4:0]            w_rd;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;
    logic [4:0]            w_imm5;
    logic                  w_legal;

    assign w_opcode = r_ir[2:0];
    assign w_rd     = r_ir[11:7];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_imm5   = r_ir[29:25];

    // Opcodes 0-3 are defined; anything with bit 2 set is illegal.
    assign w_legal  = (w_opcode[2] == 1'b0);

    // Effective address: only the low five bits of the base register take
    // part, and the sum wraps within the 32-entry data memory.
    logic [4:0]            w_eff_addr;
    assign w_eff_addr = rf_data_a[4:0] + w_imm5;

    // Handshake: only IDLE accepts, and nothing is accepted while in reset.
    logic                  w_accept;
    assign w_accept = (r_state == S_IDLE) && instr_valid;

    // Write-back enable, optionally masking writes to r0.
    logic                  w_wb_enable;
`ifdef INSTR_SEQ_ZERO_REG_EN
    assign w_wb_enable = (w_rd != 5'd0);
`else
    assign w_wb_enable = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Result register load selection
    //   EXEC of ADD/SUB captures the ALU output; MEM captures the memory read
    //   data, which arrives the cycle after the EXEC read strobe.
    // ------------------------------------------------------------------------
    logic                  w_result_load;
    logic [WORDSIZE-1:0]   w_result_next;

    always_comb begin
        w_result_load = 1'b0;
        w_result_next = '0;
        if (r_state == S_EXEC && (w_opcode == c_OP_ADD || w_opcode == c_OP_SUB)) begin
            w_result_load = 1'b1;
            w_result_next = alu_result;
        end else if (r_state == S_MEM) begin
            w_result_load = 1'b1;
            w_result_next = dm_data_output;
        end
    end

    // ------------------------------------------------------------------------
    // State, instruction and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ir     <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_ir <= instruction;
            end
            if (w_result_load) begin
                r_result <= w_result_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next_state = w_legal ? S_EXEC : S_IDLE;
            end
            S_EXEC: begin
                case (w_opcode)
                    c_OP_LW:  w_next_state = S_MEM;
                    c_OP_SW:  w_next_state = S_IDLE;   // store completes here
                    c_OP_ADD,
                    c_OP_SUB: w_next_state = S_WB;
                    default:  w_next_state = S_IDLE;   // unreachable: DECODE filters
                endcase
            end
            S_MEM: begin
                w_next_state = S_WB;
            end
            S_WB: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore outputs
    //   Everything is forced low while rst is high; IDLE would otherwise
    //   raise instr_ready during reset.
    // ------------------------------------------------------------------------
    always_comb begin
        instr_ready     = 1'b0;
        done            = 1'b0;
        illegal         = 1'b0;
        rf_write_enable = 1'b0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        rf_addr_a       = '0;
        rf_addr_b       = '0;
        alu_op          = 1'b0;
        dm_write_enable = 1'b0;
        dm_addr         = '0;
        dm_data_input   = '0;
        dm_read         = 1'b0;

        if (!rst) begin
            if (r_state != S_IDLE) begin
                rf_addr_a = w_rs1;
                rf_addr_b = w_rs2;
            end

            case (r_state)
                S_IDLE: begin
                    instr_ready = 1'b1;
                end
                S_DECODE: begin
                    illegal = !w_legal;
                end
                S_EXEC: begin
                    case (w_opcode)
                        c_OP_ADD,
                        c_OP_SUB: begin
                            alu_op = w_opcode[0];
                        end
                        c_OP_LW: begin
                            dm_addr = w_eff_addr;
                            dm_read = 1'b1;
                        end
                        c_OP_SW: begin
                            dm_addr         = w_eff_addr;
                            dm_data_input   = rf_data_b;
                            dm_write_enable = 1'b1;
                            done            = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                S_MEM: begin
                end
                S_WB: begin
                    rf_write_enable = w_wb_enable;
                    rf_write_addr   = w_rd;
                    rf_write_data   = r_result;
                    done            = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Instruction bits and base-register bits that carry no meaning here.
    logic w_unused;
    assign w_unused = ^{r_ir[SIZE-1:30], r_ir[14:12], r_ir[6:3],
                        rf_data_a[WORDSIZE-1:5]};

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer. Models the register
//               file, ALU and synchronous data memory; expected register-file
//               and data-memory writes are queued when an instruction is
//               issued and popped as the sequencer produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic        done;
    logic        illegal;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [63:0] rf_write_data;
    logic [4:0]  rf_addr_a;
    logic [4:0]  rf_addr_b;
    logic [63:0] rf_data_a;
    logic [63:0] rf_data_b;
    logic        alu_op;
    logic [63:0] alu_result;
    logic        dm_write_enable;
    logic [4:0]  dm_addr;
    logic [63:0] dm_data_input;
    logic        dm_read;
    logic [63:0] dm_data_output = '0;

    always #5 clk = ~clk;

    instr_sequencer #(.WORDSIZE(64), .SIZE(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .done            (done),
        .illegal         (illegal),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .rf_addr_a       (rf_addr_a),
        .rf_addr_b       (rf_addr_b),
        .rf_data_a       (rf_data_a),
        .rf_data_b       (rf_data_b),
        .alu_op          (alu_op),
        .alu_result      (alu_result),
        .dm_write_enable (dm_write_enable),
        .dm_addr         (dm_addr),
        .dm_data_input   (dm_data_input),
        .dm_read         (dm_read),
        .dm_data_output  (dm_data_output)
    );

    // ---------------- datapath models ----------------
    logic [63:0] rf   [32];
    logic [63:0] dmem [32];

    assign rf_data_a  = rf[rf_addr_a];
    assign rf_data_b  = rf[rf_addr_b];
    assign alu_result = alu_op ? (rf_data_a - rf_data_b) : (rf_data_a + rf_data_b);

    always @(posedge clk) begin
        if (rf_write_enable) rf[rf_write_addr] <= rf_write_data;
        if (dm_write_enable) dmem[dm_addr]     <= dm_data_input;
        if (dm_read)         dm_data_output    <= dmem[dm_addr];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_dm;
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rf(input logic [4:0] a, input logic [63:0] d);
        exp_t e;
        e.is_dm = 1'b0; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_dm(input logic [4:0] a, input logic [63:0] d);
        exp_t e;
        e.is_dm = 1'b1; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (rf_write_enable || dm_write_enable) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", {rf_write_enable, dm_write_enable}, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_kind", dm_write_enable, e.is_dm);
                chk("sb_addr", e.is_dm ? dm_addr : rf_write_addr, e.addr);
                chk("sb_data", e.is_dm ? dm_data_input : rf_write_data, e.data);
            end
        end
    endtask

    // Advance one cycle and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    // Offer an instruction, wait (bounded) for ready, and return in cycle t1.
    task automatic issue(input logic [31:0] ins);
        int waited;
        waited      = 0;
        instr_valid = 1'b1;
        instruction = ins;
        while (!instr_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!instr_ready) chk("ready_timeout", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {instr_ready, done, illegal, rf_write_enable,
                            alu_op, dm_write_enable, dm_read}, 0);
        chk({tag, "_addr"}, {rf_write_addr, rf_addr_a, rf_addr_b, dm_addr}, 0);
        chk({tag, "_wdata"}, rf_write_data, 0);
        chk({tag, "_dmin"}, dm_data_input, 0);
    endtask

    localparam logic [31:0] I_ADD   = 32'h0020_8182;  // r3 = r1 + r2
    localparam logic [31:0] I_SUB   = 32'h0020_8183;  // r3 = r1 - r2
    localparam logic [31:0] I_SUBW  = 32'h0011_0283;  // r5 = r2 - r1
    localparam logic [31:0] I_SW    = 32'h0820_8001;  // mem[r1+4] = r2
    localparam logic [31:0] I_LW    = 32'h0800_8200;  // r4 = mem[r1+4]
    localparam logic [31:0] I_ILL   = 32'h0000_0005;
    localparam logic [31:0] I_ADD0  = 32'h0020_8002;  // r0 = r1 + r2

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        for (int i = 0; i < 32; i++) begin
            rf[i]   <= '0;
            dmem[i] <= '0;
        end
        rf[1] <= 64'd10;
        rf[2] <= 64'd3;

        // Reset state
        #2;
        check_all_zero("reset");
        #10;
        rst = 1'b0;
        tick();
        chk("ready_after_reset", instr_ready, 1);

        // ADD, with a SUB held on the bus while the ADD is busy
        push_rf(5'd3, 64'd13);
        issue(I_ADD);
        chk("add_t1_done", done, 0);
        chk("add_t1_ready", instr_ready, 0);
        chk("add_rf_addr_a", rf_addr_a, 1);
        chk("add_rf_addr_b", rf_addr_b, 2);
        instr_valid = 1'b1;
        instruction = I_SUB;
        push_rf(5'd3, 64'd7);
        tick();
        chk("add_alu_op", alu_op, 0);
        chk("add_t2_done", done, 0);
        chk("busy_t2_ready", instr_ready, 0);
        tick();
        chk("add_t3_done", done, 1);
        chk("busy_t3_ready", instr_ready, 0);

        // SUB (accepted only once the ADD has finished)
        issue(I_SUB);
        tick();
        chk("sub_alu_op", alu_op, 1);
        tick();
        chk("sub_t3_done", done, 1);
        tick();
        chk("rf3_after_sub", rf[3], 64'd7);

        // SUB with underflow wrap: r5 = 3 - 10
        push_rf(5'd5, 64'hFFFF_FFFF_FFFF_FFF9);
        issue(I_SUBW);
        tick();
        tick();
        chk("subw_t3_done", done, 1);
        tick();

        // SW: mem[14] = 3
        push_dm(5'd14, 64'd3);
        issue(I_SW);
        chk("sw_t1_done", done, 0);
        tick();
        chk("sw_t2_done", done, 1);
        chk("sw_t2_dm_we", dm_write_enable, 1);
        chk("sw_t2_dm_read", dm_read, 0);
        tick();
        chk("sw_t3_ready", instr_ready, 1);

        // LW: r4 = mem[14]
        push_rf(5'd4, 64'd3);
        issue(I_LW);
        tick();
        chk("lw_t2_dm_read", dm_read, 1);
        chk("lw_t2_dm_addr", dm_addr, 14);
        chk("lw_t2_done", done, 0);
        tick();
        chk("lw_t3_done", done, 0);
        chk("lw_t3_dm_read", dm_read, 0);
        tick();
        chk("lw_t4_done", done, 1);
        tick();

        // Address wrap: r1 = 30, 30 + 4 -> 2
        rf[1] <= 64'd30;
        push_dm(5'd2, 64'd3);
        issue(I_SW);
        tick();
        chk("wrap_dm_addr", dm_addr, 2);
        tick();

        // Illegal opcode
        issue(I_ILL);
        chk("ill_t1_illegal", illegal, 1);
        chk("ill_t1_done", done, 0);
        chk("ill_t1_writes", {rf_write_enable, dm_write_enable}, 0);
        tick();
        chk("ill_t2_illegal", illegal, 0);
        chk("ill_t2_ready", instr_ready, 1);

        // Reset asserted while an LW sits in MEM
        rf[4] <= 64'h55;
        issue(I_LW);
        tick();
        tick();
        chk("mem_rf_addr_a", rf_addr_a, 1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        #3;
        rst = 1'b0;
        tick();
        chk("midrst_ready", instr_ready, 1);
        tick();
        chk("midrst_r4_kept", rf[4], 64'h55);

        // ADD after reset: r3 = 30 + 3
        push_rf(5'd3, 64'd33);
        issue(I_ADD);
        tick();
        tick();
        chk("add2_t3_done", done, 1);
        tick();
        chk("rf3_after_add2", rf[3], 64'd33);

        // Write-back to r0
`ifndef INSTR_SEQ_ZERO_REG_EN
        push_rf(5'd0, 64'd33);
`endif
        issue(I_ADD0);
        tick();
        tick();
        chk("r0_done", done, 1);
`ifdef INSTR_SEQ_ZERO_REG_EN
        chk("r0_write_enable", rf_write_enable, 0);
`else
        chk("r0_write_enable", rf_write_enable, 1);
`endif
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
